// File: rtl/maze_pkg.sv
// Shared constants and state encoding for the maze memory row controller.
// The read-latency range sets the width of the controller's wait counter.
package maze_pkg;

    localparam int COORD_W = 4;
    localparam int ROW_W   = 1 << COORD_W;

    // Largest read latency the wait counter is sized for (legal RD_LAT is 0..RD_LAT_MAX).
    localparam int RD_LAT_MAX = 3;
    localparam int WAIT_W     = $clog2(RD_LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_BIT = 2'd1,
        WR_BIT = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/maze_row_ctrl.sv
// Row-at-a-time controller for the bit-addressed 16x16 maze memory: a single
// start request becomes 16 sequential 1-bit reads or writes on the memory port.
module maze_row_ctrl
    import maze_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               op_wr,
    input  logic [COORD_W-1:0] row,
    input  logic [ROW_W-1:0]   wdata,
    output logic [ROW_W-1:0]   rdata,
    output logic               busy,
    output logic               done,
    output logic [COORD_W-1:0] mem_X,
    output logic [COORD_W-1:0] mem_Y,
    output logic               mem_RD,
    output logic               mem_WR,
    output logic               mem_D_in,
    input  logic               mem_D_out
);

    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(ROW_W - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(RD_LAT);

    state_t               state_q, state_n;
    logic [COORD_W-1:0]   x_q, x_n;
    logic [WAIT_W-1:0]    wait_q, wait_n;
    logic [COORD_W-1:0]   row_l, row_n;
    logic [ROW_W-1:0]     wdata_l, wdata_n;
    logic [ROW_W-1:0]     shadow_q, shadow_n;

    logic [ROW_W-1:0]     rdata_n;
    logic                 busy_n;
    logic                 done_n;
    logic [COORD_W-1:0]   mem_x_n;
    logic [COORD_W-1:0]   mem_y_n;
    logic                 mem_rd_n;
    logic                 mem_wr_n;
    logic                 mem_d_in_n;
    logic                 active_n;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n  = state_q;
        x_n      = x_q;
        wait_n   = wait_q;
        row_n    = row_l;
        wdata_n  = wdata_l;
        shadow_n = shadow_q;
        rdata_n  = rdata;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    row_n   = row;
                    wdata_n = wdata;
                    x_n     = '0;
                    wait_n  = '0;
                    state_n = op_wr ? WR_BIT : RD_BIT;
                end
            end

            RD_BIT: begin
                // Address is held for RD_LAT+1 cycles; D_out is valid in the last one.
                if (wait_q == WAIT_LAST) begin
                    shadow_n[x_q] = mem_D_out;
                    wait_n        = '0;
                    if (x_q == X_LAST) begin
                        state_n = DONE;
                        rdata_n = shadow_n;
                    end else begin
                        x_n = x_q + 1'b1;
                    end
                end else begin
                    wait_n = wait_q + 1'b1;
                end
            end

            WR_BIT: begin
                if (x_q == X_LAST) begin
                    state_n = DONE;
                end else begin
                    x_n = x_q + 1'b1;
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Port values are decoded from the next state and registered, so the
        // memory strobes never see a combinational path from client inputs.
        active_n   = (state_n == RD_BIT) || (state_n == WR_BIT);
        mem_rd_n   = (state_n == RD_BIT);
        mem_wr_n   = (state_n == WR_BIT);
        mem_x_n    = active_n ? x_n   : '0;
        mem_y_n    = active_n ? row_n : '0;
        mem_d_in_n = (state_n == WR_BIT) ? wdata_n[x_n] : 1'b0;
        busy_n     = (state_n != IDLE);
        done_n     = (state_n == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            wait_q   <= '0;
            row_l    <= '0;
            wdata_l  <= '0;
            shadow_q <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_X    <= '0;
            mem_Y    <= '0;
            mem_RD   <= 1'b0;
            mem_WR   <= 1'b0;
            mem_D_in <= 1'b0;
        end else begin
            state_q  <= state_n;
            x_q      <= x_n;
            wait_q   <= wait_n;
            row_l    <= row_n;
            wdata_l  <= wdata_n;
            shadow_q <= shadow_n;
            rdata    <= rdata_n;
            busy     <= busy_n;
            done     <= done_n;
            mem_X    <= mem_x_n;
            mem_Y    <= mem_y_n;
            mem_RD   <= mem_rd_n;
            mem_WR   <= mem_wr_n;
            mem_D_in <= mem_d_in_n;
        end
    end

endmodule

// File: doc/maze_row_ctrl.md
Name: maze_row_ctrl

Overview:
- Initiator/controller that drives the bit-addressed 16x16 maze memory (X = column, Y = row, 1-bit D_in/D_out, RD/WR strobes).
- Converts a single row request into 16 sequential bit accesses:
  - row read: assembles memory[Y] into a 16-bit word;
  - row write: serialises a 16-bit word into memory[Y].
- Sits between the maze-solver/loader logic and the maze memory.
- Uses a start/busy/done handshake on the client side.

Parameters:
- COORD_W, 4, width of X/Y coordinates.
- ROW_W, 16, bits per row (= 2**COORD_W).
- RD_LAT, 1, cycles from address+RD presented to valid D_out (legal 0..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- op_wr  in  1  0 = row read, 1 = row write; latched with start.
- row  in  COORD_W  target row Y; latched with start.
- wdata  in  ROW_W  write word, bit i -> memory[row][i]; latched with start.
- rdata  out  ROW_W  last completed read word, bit i = memory[row][i].
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- mem_X  out  COORD_W  column address to memory.
- mem_Y  out  COORD_W  row address to memory.
- mem_RD  out  1  read strobe.
- mem_WR  out  1  write strobe.
- mem_D_in  out  1  write data bit.
- mem_D_out  in  1  read data bit from memory.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high (clk, rst).
  - On rst: state=IDLE; rdata=0, busy=0, done=0, mem_RD=0, mem_WR=0, mem_X=0, mem_Y=0, mem_D_in=0.
  - Internal row/op/wdata latches and the bit counter x are cleared.
- States: IDLE, RD_BIT, WR_BIT, DONE.
- IDLE:
  - All memory strobes low; mem_X=0, mem_Y=0.
  - start=1 at an edge: latch row/op_wr/wdata, x=0, wait counter=0.
  - Go to RD_BIT (op_wr=0) or WR_BIT (op_wr=1).
- RD_BIT:
  - Drive mem_RD=1, mem_Y=row, mem_X=x, held constant for RD_LAT+1 cycles.
  - At the edge ending the last cycle, sample mem_D_out into rd_shadow[x].
  - If x==15 go to DONE, else x=x+1.
  - Per-bit cost is RD_LAT+1 cycles; a full read is 16*(RD_LAT+1) cycles.
- WR_BIT:
  - Drive mem_WR=1, mem_Y=row, mem_X=x, mem_D_in=wdata_l[x] for exactly 1 cycle per bit.
  - If x==15 go to DONE, else x=x+1.
  - A full write is 16 cycles.
- DONE:
  - done=1 and busy=1 for one cycle; strobes low.
  - On a read, rdata is loaded from rd_shadow at the edge entering DONE, so rdata is valid while done=1.
  - rdata is unchanged on a write.
  - Next state is IDLE.
- Latency, measured from the edge that accepts start:
  - read: done high in cycle 16*(RD_LAT+1)+1 (33 cycles with RD_LAT=1);
  - write: done high in cycle 17.
- Invariants and boundaries:
  - mem_RD and mem_WR are never high simultaneously.
  - Strobes change only on clock edges; no glitch paths from inputs to mem_* outputs.
  - start outside IDLE (including in DONE) is ignored and not queued.
  - start and rst high together: rst wins.
  - x stops at 15 and never wraps to 0 within an operation.
  - rst mid-operation: abort, strobes low from the next cycle, no done pulse, rdata=0; a partial row write may remain in memory.
  - Changes on row/wdata/op_wr while busy have no effect.
  - Back-to-back ops: start may be accepted in the IDLE cycle immediately after DONE.

Decomposition:
- maze_pkg shared package contains:
  - COORD_W, ROW_W constants;
  - enum state_t {IDLE, RD_BIT, WR_BIT, DONE};
  - the RD_LAT legal-range check constant.
- Single module; no sub-module is natural.
- The bit counter and wait counter stay inline.

Test Plan:
- Setup: behavioural maze memory model, RD_LAT=1, preloaded.
- Read row 0 preloaded 16'hA5C3:
  - start, op_wr=0, row=0 -> mem_X steps 0..15, each held 2 cycles, with mem_RD=1;
  - done at cycle 33; rdata=16'hA5C3; busy low the cycle after.
- Write row 7 with wdata=16'h1234, then read row 7:
  - 16 WR cycles, mem_D_in matching wdata[x], done at cycle 17;
  - read returns 16'h1234; other rows unchanged.
- Boundary rows:
  - write 16'hFFFF to row 15, 16'h0001 to row 0;
  - read both back exactly; mem_X never exceeds 15.
- Ignored start:
  - pulse start with op_wr=1, row=3 at cycle 5 of a row-2 read;
  - no write occurs, the row-2 read completes normally, exactly one done.
- Reset mid-write:
  - assert rst at bit 8 of a row-4 write of 16'hFFFF (row preloaded 0);
  - strobes low next cycle, no done, rdata=0;
  - memory row 4 = 16'h00FF (bits 0..7 written, bit 8 not).
